// File: rtl/sync_mem_fifo_if.sv
// Producer/consumer bundle for sync_mem_fifo.
// The master modport drives pushes/pops; the slave modport is the FIFO side.
interface sync_mem_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             write_enable;
  logic [WIDTH-1:0] write_data;
  logic             read_enable;
  logic [WIDTH-1:0] read_data;
  logic             read_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;
  logic             clear_err;

  modport master (
    output write_enable, write_data,
    output read_enable, clear_err,
    input  read_data, read_valid,
    input  full, empty,
    input  almost_full, almost_empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  write_enable, write_data,
    input  read_enable, clear_err,
    output read_data, read_valid,
    output full, empty,
    output almost_full, almost_empty,
    output count, overflow, underflow
  );
endinterface

// File: rtl/sync_mem_fifo.sv
// Single-clock register-array FIFO with count, thresholds and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads.
module sync_mem_fifo #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  sync_mem_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [CW-1:0] ptr_t;

  localparam ptr_t AF_T = ptr_t'(AFULL_THRESH);
  localparam ptr_t AE_T = ptr_t'(AEMPTY_THRESH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t cnt_q, cnt_d;

  logic full_q, full_d;
  logic empty_q, empty_d;
  logic af_q, af_d;
  logic ae_q, ae_d;
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  logic push, pop;

  logic [AW-1:0] wr_idx, rd_idx;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];

  always_comb begin
    pop  = bus.read_enable && !empty_q;
    // A pop frees a slot, so a full FIFO still takes a same-cycle push
    push = bus.write_enable && (!full_q || pop);

    wr_ptr_d = wr_ptr_q + ptr_t'(push);
    rd_ptr_d = rd_ptr_q + ptr_t'(pop);

    cnt_d = cnt_q;
    unique case (1'b1)
      (push && !pop): cnt_d = cnt_q + 1'b1;
      (pop && !push): cnt_d = cnt_q - 1'b1;
      default:        cnt_d = cnt_q;
    endcase

    full_d  = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0])
           && (wr_ptr_d[AW] != rd_ptr_d[AW]);
    empty_d = (wr_ptr_d == rd_ptr_d);
    af_d    = (cnt_d >= AF_T);
    ae_d    = (cnt_d <= AE_T);

    ovf_d = ovf_q | (bus.write_enable & ~push);
    unf_d = unf_q | (bus.read_enable & empty_q);
    if (bus.clear_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_idx] <= bus.write_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

`ifdef FIFO_FWFT_EN
  assign bus.read_data  = mem_q[rd_idx];
  assign bus.read_valid = !empty_q;
`else
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (pop) rdata_q <= mem_q[rd_idx];
      rvalid_q <= pop;
    end
  end

  assign bus.read_data  = rdata_q;
  assign bus.read_valid = rvalid_q;
`endif

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = cnt_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_mem_fifo.sv
// Scoreboard bench for sync_mem_fifo (WIDTH=8, DEPTH=4).
// A queue-based model predicts flags; a monitor checks popped words.
module tb_sync_mem_fifo;
  localparam int W   = 8;
  localparam int D   = 4;
  localparam int AFT = D - 2;
  localparam int AET = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sync_mem_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

  sync_mem_fifo #(
    .WIDTH(W),
    .DEPTH(D),
    .AFULL_THRESH(AFT),
    .AEMPTY_THRESH(AET)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] sb[$];
  bit m_ovf = 0;
  bit m_unf = 0;
  bit m_rv  = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_flags();
    int n;
    n = mq.size();
    chk("count", 32'(bus.count), n);
    chk("full", 32'(bus.full), 32'(n == D));
    chk("empty", 32'(bus.empty), 32'(n == 0));
    chk("almost_full", 32'(bus.almost_full), 32'(n >= AFT));
    chk("almost_empty", 32'(bus.almost_empty), 32'(n <= AET));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_unf));
`ifdef FIFO_FWFT_EN
    chk("fwft_valid", 32'(bus.read_valid), 32'(n != 0));
    if (n != 0) chk("fwft_data", 32'(bus.read_data), 32'(mq[0]));
`else
    chk("read_valid", 32'(bus.read_valid), 32'(m_rv));
`endif
  endtask

  task automatic step(bit we, logic [W-1:0] wd, bit re, bit ce);
    bit pop_ok, push_ok;
    logic [W-1:0] v;
    @(negedge clk);
    bus.write_enable = we;
    bus.write_data   = wd;
    bus.read_enable  = re;
    bus.clear_err    = ce;
    pop_ok  = re && (mq.size() != 0);
    push_ok = we && ((mq.size() < D) || pop_ok);
    if (ce) begin
      m_ovf = 0;
      m_unf = 0;
    end else begin
      m_ovf = m_ovf | (we && !push_ok);
      m_unf = m_unf | (re && mq.size() == 0);
    end
    if (pop_ok) begin
      v = mq.pop_front();
`ifndef FIFO_FWFT_EN
      sb.push_back(v);
`endif
    end
    if (push_ok) mq.push_back(wd);
    m_rv = pop_ok;
    @(posedge clk);
    #1;
    check_flags();
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    bus.clear_err    = 1'b0;
  endtask

  task automatic reset_check();
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_afull", 32'(bus.almost_full), 0);
    chk("rst_aempty", 32'(bus.almost_empty), 1);
    chk("rst_valid", 32'(bus.read_valid), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_unf", 32'(bus.underflow), 0);
`ifndef FIFO_FWFT_EN
    chk("rst_rdata", 32'(bus.read_data), 0);
`endif
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    bus.clear_err    = 1'b0;
    #1;
    reset_check();
    mq.delete();
    sb.delete();
    m_ovf = 0;
    m_unf = 0;
    m_rv  = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifndef FIFO_FWFT_EN
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && bus.read_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_pop: read_valid=1 expected no word at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("read_data", 32'(bus.read_data), 32'(e));
      end
    end
  end
`endif

  initial begin
    bus.write_enable = 1'b0;
    bus.write_data   = '0;
    bus.read_enable  = 1'b0;
    bus.clear_err    = 1'b0;
    repeat (2) @(negedge clk);
    reset_check();
    rst_n = 1'b1;

    // fill to full
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0);
    step(1, 8'h44, 0, 0);
    chk("t1_full", 32'(bus.full), 1);
    chk("t1_count", 32'(bus.count), 4);

    // overflow, then drain in order
    step(1, 8'h55, 0, 0);
    chk("t2_ovf", 32'(bus.overflow), 1);
    repeat (4) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 1);

    // underflow with simultaneous push, no bypass
    step(1, 8'hA5, 1, 0);
    chk("t3_unf", 32'(bus.underflow), 1);
    chk("t3_valid", 32'(bus.read_valid), 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 1);

    // full push+pop, wrap
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0);
    step(1, 8'h44, 0, 0);
    step(1, 8'h66, 1, 0);
    chk("t4_count", 32'(bus.count), 4);
    for (int i = 0; i < 8; i++) step(1, W'($urandom), 1, 0);
    // clear_err wins over same-cycle overflow
    step(1, 8'h77, 0, 1);
    step(1, 8'h78, 0, 0);
    step(0, 8'h00, 0, 1);

    // reset mid-stream at count 3
    step(0, 8'h00, 1, 0);
    chk("t5_pre", 32'(bus.count), 3);
    mid_reset();
    step(0, 8'h00, 1, 0);
    chk("t5_unf", 32'(bus.underflow), 1);

    // randomized phases: fill-heavy, balanced, drain-heavy
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 400; i++) begin
        int pw, pr;
        pw = (ph == 0) ? 80 : (ph == 1) ? 50 : 25;
        pr = (ph == 0) ? 25 : (ph == 1) ? 50 : 80;
        step($urandom_range(99) < pw, W'($urandom),
             $urandom_range(99) < pr, $urandom_range(19) == 0);
      end
    end

    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    chk("sb_drain", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
